// File: rtl/seg_code_rx.sv
// -----------------------------------------------------------------------------
// seg_code_rx
// Receive side of the 7-segment display link. Two active-low digit buses are
// synchronised, debounced by a stability filter and decoded back into an
// 8-bit code {digit1, digit0} with a one-cycle change strobe.
//
// Parameters
//   SYNC_STAGES    input synchroniser depth (>= 2)
//   STABLE_CYCLES  cycles a synced pattern must hold before acceptance (>= 1)
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   hex_n0      in   [6:0] low digit segments, active-low, bit6=g .. bit0=a
//   hex_n1      in   [6:0] high digit segments, same encoding
//   code        out  [7:0] last valid decoded value {digit1, digit0}
//   code_valid  out  one-cycle pulse when code takes a new value
//   err         out  level: last accepted pattern held an illegal digit
//   upd_cnt     out  [7:0] count of code_valid pulses, wraps 255 -> 0
//                    (present only when SEG_RX_CNT_EN is defined)
//
// Optional feature macro: SEG_RX_CNT_EN
// -----------------------------------------------------------------------------
module seg_code_rx #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] hex_n0,
    input  logic [6:0] hex_n1,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       err
`ifdef SEG_RX_CNT_EN
    ,
    output logic [7:0] upd_cnt
`endif
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [13:0]       BLANK    = 14'h3FFF;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // Segment pattern to {legal, nibble}; anything outside the glyph set
    // (blank included) is reported as illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h40:   res = 5'h10;
            7'h79:   res = 5'h11;
            7'h24:   res = 5'h12;
            7'h30:   res = 5'h13;
            7'h19:   res = 5'h14;
            7'h12:   res = 5'h15;
            7'h02:   res = 5'h16;
            7'h78:   res = 5'h17;
            7'h00:   res = 5'h18;
            7'h10:   res = 5'h19;
            7'h08:   res = 5'h1A;
            7'h03:   res = 5'h1B;
            7'h46:   res = 5'h1C;
            7'h21:   res = 5'h1D;
            7'h06:   res = 5'h1E;
            7'h0E:   res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    logic [13:0]      sync_q [SYNC_STAGES];
    logic [13:0]      sync_s;
    logic [13:0]      prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept_s;
    logic [4:0]       dig0_s, dig1_s;
    logic             legal_s;
    logic [7:0]       dec_s;
    logic [7:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             seen_q, seen_d;

    // Input synchroniser chain; resets to an all-blank display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= BLANK;
            end
        end else begin
            sync_q[0] <= {hex_n1, hex_n0};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Stability filter next state: any change restarts the count, which then
    // saturates so an unchanging pattern is accepted only once.
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (sync_s != prev_q) begin
            prev_d = sync_s;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign accept_s = (sync_s == prev_q) && (cnt_q == CNT_LAST);

    assign dig0_s  = seg_decode(sync_s[6:0]);
    assign dig1_s  = seg_decode(sync_s[13:7]);
    assign legal_s = dig0_s[4] & dig1_s[4];
    assign dec_s   = {dig1_s[3:0], dig0_s[3:0]};

    // Output next state. seen_q forces a pulse on the first legal accept after
    // reset even when the decoded value equals the reset value of code.
    always_comb begin
        code_d  = code_q;
        valid_d = 1'b0;
        err_d   = err_q;
        seen_d  = seen_q;
        if (accept_s) begin
            if (legal_s) begin
                err_d  = 1'b0;
                seen_d = 1'b1;
                if ((dec_s != code_q) || !seen_q) begin
                    code_d  = dec_s;
                    valid_d = 1'b1;
                end else begin
                    code_d  = code_q;
                    valid_d = 1'b0;
                end
            end else begin
                err_d = 1'b1;
            end
        end else begin
            err_d = err_q;
        end
    end

    // Filter and output state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= BLANK;
            cnt_q   <= '0;
            code_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
        end
    end

    assign code       = code_q;
    assign code_valid = valid_q;
    assign err        = err_q;

`ifdef SEG_RX_CNT_EN
    logic [7:0] upd_q, upd_d;

    // Update counter advances together with the code_valid pulse it counts.
    always_comb begin
        if (valid_d) begin
            upd_d = upd_q + 8'd1;
        end else begin
            upd_d = upd_q;
        end
    end

    // Update counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_q <= 8'd0;
        end else begin
            upd_q <= upd_d;
        end
    end

    assign upd_cnt = upd_q;
`endif

endmodule

// File: tb/tb_seg_code_rx.sv
module tb_seg_code_rx;

    logic       clk;
    logic       rst_n;
    logic [6:0] hex_n0;
    logic [6:0] hex_n1;
    logic [7:0] code;
    logic       code_valid;
    logic       err;
`ifdef SEG_RX_CNT_EN
    logic [7:0] upd_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;
    logic prev_cv = 1'b0;
    logic [7:0] exp_q [$];

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_code_rx #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hex_n0     (hex_n0),
        .hex_n1     (hex_n1),
        .code       (code),
        .code_valid (code_valid),
        .err        (err)
`ifdef SEG_RX_CNT_EN
        ,
        .upd_cnt    (upd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] h1, input logic [6:0] h0);
        hex_n1 = h1;
        hex_n0 = h0;
    endtask

    // Follow edges 1..8 after a drive: nothing before edge 7, outcome at edge 7.
    task automatic watch7(input string tag, input logic exp_v, input logic [7:0] exp_code,
                          input logic exp_err, input logic err_before);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k < 7) chk({tag, "_early_valid"}, {31'd0, code_valid}, 32'd0);
            if (k == 6) chk({tag, "_err_before"}, {31'd0, err}, {31'd0, err_before});
        end
        chk({tag, "_valid7"}, {31'd0, code_valid}, {31'd0, exp_v});
        chk({tag, "_code7"}, {24'd0, code}, {24'd0, exp_code});
        chk({tag, "_err7"}, {31'd0, err}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, "_valid8"}, {31'd0, code_valid}, 32'd0);
    endtask

    // Scoreboard side: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (code_valid) begin
            pulse_cnt++;
            chk("pulse_not_back_to_back", {31'd0, prev_cv}, 32'd0);
            chk("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                chk("pulse_code", {24'd0, code}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_cv <= code_valid;
    end

    initial begin
        int p0;
        logic [7:0] val;
`ifdef SEG_RX_CNT_EN
        logic [7:0] u0;
`endif
        rst_n = 1'b0;
        drive(7'h7F, 7'h7F);
        repeat (3) @(negedge clk);
        chk("rst_code", {24'd0, code}, 32'd0);
        chk("rst_valid", {31'd0, code_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
`ifdef SEG_RX_CNT_EN
        chk("rst_upd", {24'd0, upd_cnt}, 32'd0);
`endif
        rst_n = 1'b1;

        // Blank display after reset is accepted as an illegal pattern.
        repeat (8) @(negedge clk);
        chk("blank_err", {31'd0, err}, 32'd1);
        chk("blank_code", {24'd0, code}, 32'd0);

        // Code 0x10: digit1 = '1', digit0 = '0'.
        drive(7'h79, 7'h40);
        exp_q.push_back(8'h10);
        watch7("c10", 1'b1, 8'h10, 1'b0, 1'b1);

        // Holding the same pattern produces no further pulse.
        p0 = pulse_cnt;
        repeat (50) @(negedge clk);
        chk("hold_no_pulse", pulse_cnt - p0, 32'd0);

        // 0xFE with a two-cycle 00/00 glitch part way through the filter.
        p0 = pulse_cnt;
        drive(7'h0E, 7'h06);
        exp_q.push_back(8'hFE);
        repeat (2) @(negedge clk);
        drive(7'h00, 7'h00);
        repeat (2) @(negedge clk);
        drive(7'h0E, 7'h06);
        for (int k = 0; k < 30; k++) @(negedge clk);
        chk("glitch_single_pulse", pulse_cnt - p0, 32'd1);
        chk("glitch_code", {24'd0, code}, 32'hFE);
        chk("glitch_err", {31'd0, err}, 32'd0);

        // Blank low digit: error, code held, no pulse.
        drive(7'h0E, 7'h7F);
        watch7("err_set", 1'b0, 8'hFE, 1'b1, 1'b0);
        // Back to the old value: error clears, no pulse since code is unchanged.
        drive(7'h0E, 7'h06);
        watch7("err_clr_same", 1'b0, 8'hFE, 1'b0, 1'b1);
        // Low digit '0': new value 0xF0.
        drive(7'h0E, 7'h40);
        exp_q.push_back(8'hF0);
        watch7("cF0", 1'b1, 8'hF0, 1'b0, 1'b0);

        // Reset during filtering clears outputs at once.
        drive(7'h30, 7'h30);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_code", {24'd0, code}, 32'd0);
        chk("midrst_valid", {31'd0, code_valid}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
`ifdef SEG_RX_CNT_EN
        chk("midrst_upd", {24'd0, upd_cnt}, 32'd0);
`endif
        drive(7'h40, 7'h40);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // First legal accept after reset pulses even though code stays 0x00.
        exp_q.push_back(8'h00);
        watch7("first00", 1'b1, 8'h00, 1'b0, 1'b0);

`ifdef SEG_RX_CNT_EN
        chk("upd_after_first", {24'd0, upd_cnt}, 32'd1);
        u0 = upd_cnt;
        for (int i = 0; i < 256; i++) begin
            val = 8'(i + 1);
            drive(glyph[val[7:4]], glyph[val[3:0]]);
            exp_q.push_back(val);
            repeat (8) @(negedge clk);
            if (i == 127) chk("upd_half", {24'd0, upd_cnt}, {24'd0, 8'(u0 + 8'd128)});
        end
        chk("upd_wrap", {24'd0, upd_cnt}, {24'd0, u0});
`endif

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
